// File: rtl/commit_trace_buffer.sv
// Commit-trace capture buffer: packs up to NrCommitPorts retirements plus one exception per cycle
// into a circular buffer drained over valid/ready. Optional timestamps: COMMIT_TRACE_TIMESTAMP_EN.
module commit_trace_buffer #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 16,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned VLEN          = 64,
  parameter int unsigned DropCntWidth  = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              trace_en_i,
  input  logic                              wrap_mode_i,
  input  logic                              clear_i,
  input  logic [NrCommitPorts-1:0]          commit_valid_i,
  input  logic [NrCommitPorts*VLEN-1:0]     commit_pc_i,
  input  logic [NrCommitPorts*32-1:0]       commit_instr_i,
  input  logic [NrCommitPorts*5-1:0]        commit_rd_i,
  input  logic [NrCommitPorts*XLEN-1:0]     commit_result_i,
  input  logic [1:0]                        priv_lvl_i,
  input  logic                              ex_valid_i,
  input  logic [VLEN-1:0]                   ex_pc_i,
  input  logic [XLEN-1:0]                   ex_cause_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [VLEN-1:0]                   out_pc_o,
  output logic [31:0]                       out_instr_o,
  output logic [4:0]                        out_rd_o,
  output logic [XLEN-1:0]                   out_data_o,
  output logic [1:0]                        out_priv_o,
  output logic                              out_is_ex_o,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  output logic [31:0]                       out_stamp_o,
`endif
  output logic [$clog2(Depth):0]            count_o,
  output logic                              overflow_o,
  output logic [DropCntWidth-1:0]           drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0]     stamp;
`endif
    logic [VLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [1:0]      priv;
    logic            is_ex;
  } rec_t;

  rec_t            mem_q [Depth];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [DropCntWidth-1:0] drop_q, drop_d;

  logic            pop, accept;
  logic [CntW-1:0] cv_cnt, nwr, space, excess;
  logic [CntW-1:0] port_off [NrCommitPorts];
  logic [PtrW-1:0] wr_idx [NrCommitPorts];
  logic [PtrW-1:0] ex_idx;
  rec_t            port_rec [NrCommitPorts];
  rec_t            ex_rec;
  rec_t            head_rec;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] stamp_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stamp_q <= '0;
    else         stamp_q <= stamp_q + 32'd1;
  end
`endif

  function automatic logic [DropCntWidth-1:0] sat_add(input logic [DropCntWidth-1:0] a,
                                                      input logic [CntW-1:0] b);
    logic [DropCntWidth:0] s;
    s = {1'b0, a} + (DropCntWidth+1)'(b);
    return s[DropCntWidth] ? '1 : s[DropCntWidth-1:0];
  endfunction

  // Each valid port lands after all lower-numbered valid ports.
  always_comb begin
    cv_cnt = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      port_off[p] = cv_cnt;
      cv_cnt      = cv_cnt + CntW'(commit_valid_i[p]);
    end
  end

  assign nwr    = trace_en_i ? cv_cnt + CntW'(ex_valid_i) : '0;
  assign pop    = (count_q != '0) && out_ready_i;
  assign space  = CntW'(Depth) - count_q + CntW'(pop);
  assign ex_idx = tail_q + PtrW'(cv_cnt);

  generate
    for (genvar gi = 0; gi < NrCommitPorts; gi++) begin : g_port
      assign wr_idx[gi] = tail_q + PtrW'(port_off[gi]);
      always_comb begin
        port_rec[gi]       = '0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        port_rec[gi].stamp = stamp_q;
`endif
        port_rec[gi].pc    = commit_pc_i[gi*VLEN +: VLEN];
        port_rec[gi].instr = commit_instr_i[gi*32 +: 32];
        port_rec[gi].rd    = commit_rd_i[gi*5 +: 5];
        port_rec[gi].data  = commit_result_i[gi*XLEN +: XLEN];
        port_rec[gi].priv  = priv_lvl_i;
      end
    end
  endgenerate

  always_comb begin
    ex_rec       = '0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    ex_rec.stamp = stamp_q;
`endif
    ex_rec.pc    = ex_pc_i;
    ex_rec.data  = ex_cause_i;
    ex_rec.priv  = priv_lvl_i;
    ex_rec.is_ex = 1'b1;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    excess     = '0;
    accept     = 1'b0;
    if (clear_i) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (nwr > space) begin
      overflow_d = 1'b1;
      if (wrap_mode_i) begin
        // Oldest entries are overwritten; head skips past them.
        accept  = 1'b1;
        excess  = nwr - space;
        head_d  = head_q + PtrW'(pop) + PtrW'(excess);
        count_d = CntW'(Depth);
        drop_d  = sat_add(drop_q, excess);
      end else begin
        head_d  = head_q + PtrW'(pop);
        count_d = count_q - CntW'(pop);
        drop_d  = sat_add(drop_q, nwr);
      end
    end else begin
      accept  = (nwr != '0);
      head_d  = head_q + PtrW'(pop);
      count_d = count_q - CntW'(pop) + nwr;
    end
    if (accept) tail_d = tail_q + PtrW'(nwr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int p = 0; p < NrCommitPorts; p++) begin
        if (commit_valid_i[p]) mem_q[wr_idx[p]] <= port_rec[p];
      end
      if (ex_valid_i) mem_q[ex_idx] <= ex_rec;
    end
  end

  always_comb begin
    head_rec = '0;
    if (count_q != '0) head_rec = mem_q[head_q];
  end

  assign out_valid_o = (count_q != '0);
  assign out_pc_o    = head_rec.pc;
  assign out_instr_o = head_rec.instr;
  assign out_rd_o    = head_rec.rd;
  assign out_data_o  = head_rec.data;
  assign out_priv_o  = head_rec.priv;
  assign out_is_ex_o = head_rec.is_ex;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  assign out_stamp_o = head_rec.stamp;
`endif
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_q;

endmodule
